// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle ALU control sequencer.
// Accepts an opcode through a start/ready handshake, drives one one-hot ALU
// operation line for the operation's cycle count, then captures Chigh/Clow
// into the Z pair and pulses done.
// Optional feature macro: ALU_SEQ_DIVZERO_EN (trap DIV with a zero B operand).
module alu_sequencer #(
  parameter int unsigned MUL_CYCLES = 2,
  parameter int unsigned DIV_CYCLES = 33
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        start,
  input  logic [4:0]  opcode,
  input  logic        b_zero,
  input  logic [31:0] Chigh_in,
  input  logic [31:0] Clow_in,
  output logic        ready,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        ADD,
  output logic        SUB,
  output logic        MUL,
  output logic        DIV,
  output logic        AND,
  output logic        OR,
  output logic        SHR,
  output logic        SHRA,
  output logic        SHL,
  output logic        ROR,
  output logic        ROL,
  output logic        NEG,
  output logic        NOT,
  output logic        IncPC,
  output logic [31:0] Zhigh,
  output logic [31:0] Zlow
);

  localparam int unsigned CNT_W   = 6;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned NUM_OPS = 14;

  localparam int unsigned OP_ADD   = 0;
  localparam int unsigned OP_SUB   = 1;
  localparam int unsigned OP_MUL   = 2;
  localparam int unsigned OP_DIV   = 3;
  localparam int unsigned OP_AND   = 4;
  localparam int unsigned OP_OR    = 5;
  localparam int unsigned OP_SHR   = 6;
  localparam int unsigned OP_SHRA  = 7;
  localparam int unsigned OP_SHL   = 8;
  localparam int unsigned OP_ROR   = 9;
  localparam int unsigned OP_ROL   = 10;
  localparam int unsigned OP_NEG   = 11;
  localparam int unsigned OP_NOT   = 12;
  localparam int unsigned OP_INCPC = 13;

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_OPS-1:0]  op_q, op_d;
  logic [DATA_W-1:0]   zhigh_q, zhigh_d;
  logic [DATA_W-1:0]   zlow_q, zlow_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [NUM_OPS-1:0]  dec_c;
  logic                divz_c;

  // Opcode to one-hot operation line; all-zero means illegal.
  function automatic logic [NUM_OPS-1:0] decode(input logic [4:0] code);
    logic [NUM_OPS-1:0] oh;
    oh = '0;
    case (code)
      5'b00011: oh[OP_ADD]   = 1'b1;
      5'b00100: oh[OP_SUB]   = 1'b1;
      5'b00101: oh[OP_SHR]   = 1'b1;
      5'b00110: oh[OP_SHRA]  = 1'b1;
      5'b00111: oh[OP_SHL]   = 1'b1;
      5'b01000: oh[OP_ROR]   = 1'b1;
      5'b01001: oh[OP_ROL]   = 1'b1;
      5'b01010: oh[OP_AND]   = 1'b1;
      5'b01011: oh[OP_OR]    = 1'b1;
      5'b01111: oh[OP_MUL]   = 1'b1;
      5'b10000: oh[OP_DIV]   = 1'b1;
      5'b10001: oh[OP_NEG]   = 1'b1;
      5'b10010: oh[OP_NOT]   = 1'b1;
      5'b11111: oh[OP_INCPC] = 1'b1;
      default:  oh = '0;
    endcase
    return oh;
  endfunction

`ifdef ALU_SEQ_DIVZERO_EN
  assign divz_c = b_zero;
`else
  logic unused_b_zero;
  assign unused_b_zero = b_zero;
  assign divz_c        = 1'b0;
`endif

  // Next-state, counter, result capture and next registered outputs.
  always_comb begin
    dec_c   = decode(opcode);
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    zhigh_d = zhigh_q;
    zlow_d  = zlow_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if ((dec_c != '0) && !(dec_c[OP_DIV] && divz_c)) begin
            state_d = EXEC;
            op_d    = dec_c;
            if (dec_c[OP_MUL])      cnt_d = MUL_LOAD;
            else if (dec_c[OP_DIV]) cnt_d = DIV_LOAD;
            else                    cnt_d = '0;
          end else begin
            state_d = DONE;
            err_d   = 1'b1;
          end
        end
      end
      EXEC: begin
        if (cnt_q == '0) begin
          state_d = DONE;
          op_d    = '0;
          zlow_d  = Clow_in;
          if (op_q[OP_MUL] || op_q[OP_DIV]) zhigh_d = Chigh_in;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: begin
        state_d = IDLE;
        op_d    = '0;
      end
    endcase
    ready_d = (state_d == IDLE);
    busy_d  = (state_d == EXEC);
    done_d  = (state_d == DONE);
  end

  // State and output registers; clear forces the idle/reset view at once.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      zhigh_q <= '0;
      zlow_q  <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      zhigh_q <= zhigh_d;
      zlow_q  <= zlow_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign ready = ready_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign err   = err_q;
  assign Zhigh = zhigh_q;
  assign Zlow  = zlow_q;
  assign ADD   = op_q[OP_ADD];
  assign SUB   = op_q[OP_SUB];
  assign MUL   = op_q[OP_MUL];
  assign DIV   = op_q[OP_DIV];
  assign AND   = op_q[OP_AND];
  assign OR    = op_q[OP_OR];
  assign SHR   = op_q[OP_SHR];
  assign SHRA  = op_q[OP_SHRA];
  assign SHL   = op_q[OP_SHL];
  assign ROR   = op_q[OP_ROR];
  assign ROL   = op_q[OP_ROL];
  assign NEG   = op_q[OP_NEG];
  assign NOT   = op_q[OP_NOT];
  assign IncPC = op_q[OP_INCPC];

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed self-checking bench for alu_sequencer (MUL_CYCLES=2, DIV_CYCLES=33).
module tb_alu_sequencer;

  logic        clock;
  logic        clear;
  logic        start;
  logic [4:0]  opcode;
  logic        b_zero;
  logic [31:0] Chigh_in;
  logic [31:0] Clow_in;
  logic        ready, busy, done, err;
  logic        ADD, SUB, MUL, DIV, AND, OR, SHR, SHRA, SHL, ROR, ROL, NEG, NOT, IncPC;
  logic [31:0] Zhigh, Zlow;
  logic [13:0] lines;

  int checks = 0;
  int errors = 0;
  int bcnt;
  int cyc;
  int dcnt;

  // bit0 ADD, bit1 SUB, bit2 MUL, bit3 DIV
  assign lines = {IncPC, NOT, NEG, ROL, ROR, SHL, SHRA, SHR, OR, AND, DIV, MUL, SUB, ADD};

  alu_sequencer #(.MUL_CYCLES(2), .DIV_CYCLES(33)) dut (
    .clock(clock), .clear(clear), .start(start), .opcode(opcode), .b_zero(b_zero),
    .Chigh_in(Chigh_in), .Clow_in(Clow_in),
    .ready(ready), .busy(busy), .done(done), .err(err),
    .ADD(ADD), .SUB(SUB), .MUL(MUL), .DIV(DIV), .AND(AND), .OR(OR),
    .SHR(SHR), .SHRA(SHRA), .SHL(SHL), .ROR(ROR), .ROL(ROL), .NEG(NEG),
    .NOT(NOT), .IncPC(IncPC), .Zhigh(Zhigh), .Zlow(Zlow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present a request for one edge; returns 1 time unit into cycle 1.
  task automatic go(input logic [4:0] op, input logic bz);
    @(negedge clock);
    start  = 1'b1;
    opcode = op;
    b_zero = bz;
    @(posedge clock);
    #1;
    start  = 1'b0;
    opcode = 5'b01111;
    b_zero = 1'b0;
  endtask

  // Count busy cycles until done, pulsing a stray start in cycle 5.
  task automatic run_until_done(output int busy_cycles, output int done_cycle);
    busy_cycles = 0;
    done_cycle  = 1;
    while (done_cycle < 60 && done !== 1'b1) begin
      if (busy === 1'b1) busy_cycles++;
      if (done_cycle == 5) begin
        start  = 1'b1;
        opcode = 5'b00011;
      end else begin
        start = 1'b0;
      end
      tick();
      done_cycle++;
    end
    start = 1'b0;
  endtask

  initial begin
    clear = 1'b0; start = 1'b0; opcode = '0; b_zero = 1'b0;
    Chigh_in = '0; Clow_in = '0;
    #12;
    check("rst_ready", ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_lines", lines, 0);
    check("rst_zhigh", Zhigh, 0);
    check("rst_zlow", Zlow, 0);
    clear = 1'b1;

    // MUL: two EXEC cycles, both halves captured
    Chigh_in = 32'h00000001; Clow_in = 32'h80000000;
    go(5'b01111, 1'b0);
    check("mul_c1_lines", lines, 14'h0004);
    check("mul_c1_busy", busy, 1);
    check("mul_c1_ready", ready, 0);
    tick();
    check("mul_c2_lines", lines, 14'h0004);
    tick();
    check("mul_c3_done", done, 1);
    check("mul_c3_err", err, 0);
    check("mul_c3_lines", lines, 0);
    check("mul_zhigh", Zhigh, 32'h00000001);
    check("mul_zlow", Zlow, 32'h80000000);
    tick();
    check("mul_c4_ready", ready, 1);

    // Preset Zhigh to 0xAAAAAAAA with another MUL
    Chigh_in = 32'hAAAAAAAA; Clow_in = 32'h00000000;
    go(5'b01111, 1'b0);
    tick(); tick(); tick();
    check("preset_zhigh", Zhigh, 32'hAAAAAAAA);

    // ADD: one cycle, Zlow only
    Chigh_in = 32'h55555555; Clow_in = 32'h00000007;
    go(5'b00011, 1'b0);
    check("add_c1_lines", lines, 14'h0001);
    tick();
    check("add_c2_done", done, 1);
    check("add_c2_err", err, 0);
    check("add_c2_lines", lines, 0);
    check("add_zlow", Zlow, 32'h00000007);
    check("add_zhigh_hold", Zhigh, 32'hAAAAAAAA);
    tick();
    check("add_c3_ready", ready, 1);

    // Illegal opcode 01100
    Chigh_in = 32'h00001234; Clow_in = 32'h00005678;
    go(5'b01100, 1'b0);
    check("ill_c1_done", done, 1);
    check("ill_c1_err", err, 1);
    check("ill_c1_lines", lines, 0);
    check("ill_c1_busy", busy, 0);
    check("ill_zhigh", Zhigh, 32'hAAAAAAAA);
    check("ill_zlow", Zlow, 32'h00000007);
    tick();
    check("ill_c2_ready", ready, 1);
    check("ill_c2_err", err, 0);

    // DIV: 33 busy cycles, stray start in cycle 5 ignored
    Chigh_in = 32'h0000000D; Clow_in = 32'h0000000E;
    go(5'b10000, 1'b0);
    check("div_c1_lines", lines, 14'h0008);
    run_until_done(bcnt, cyc);
    check("div_busy_cycles", 64'(bcnt), 33);
    check("div_done_cycle", 64'(cyc), 34);
    check("div_err", err, 0);
    check("div_zhigh", Zhigh, 32'h0000000D);
    check("div_zlow", Zlow, 32'h0000000E);
    tick();
    check("div_ready", ready, 1);
    tick();
    check("div_no_queue_busy", busy, 0);
    check("div_no_queue_ready", ready, 1);

    // DIV with b_zero=1
    Chigh_in = 32'h0F0F0F0F; Clow_in = 32'hF0F0F0F0;
    go(5'b10000, 1'b1);
`ifdef ALU_SEQ_DIVZERO_EN
    check("dz_c1_done", done, 1);
    check("dz_c1_err", err, 1);
    check("dz_c1_lines", lines, 0);
    check("dz_zhigh", Zhigh, 32'h0000000D);
    check("dz_zlow", Zlow, 32'h0000000E);
    tick();
    check("dz_ready", ready, 1);
`else
    run_until_done(bcnt, cyc);
    check("dz_busy_cycles", 64'(bcnt), 33);
    check("dz_done_cycle", 64'(cyc), 34);
    check("dz_err", err, 0);
    check("dz_zhigh", Zhigh, 32'h0F0F0F0F);
    check("dz_zlow", Zlow, 32'hF0F0F0F0);
    tick();
    check("dz_ready", ready, 1);
`endif

    // clear in cycle 10 of a DIV
    Chigh_in = 32'h00000099; Clow_in = 32'h00001234;
    go(5'b10000, 1'b0);
    for (int i = 0; i < 9; i++) tick();
    check("clr_pre_busy", busy, 1);
    #1 clear = 1'b0;
    #1;
    check("clr_ready", ready, 1);
    check("clr_busy", busy, 0);
    check("clr_done", done, 0);
    check("clr_err", err, 0);
    check("clr_lines", lines, 0);
    check("clr_zhigh", Zhigh, 0);
    check("clr_zlow", Zlow, 0);
    @(negedge clock);
    clear = 1'b1;
    go(5'b00011, 1'b0);
    check("clr_add_lines", lines, 14'h0001);
    tick();
    check("clr_add_done", done, 1);
    check("clr_add_zlow", Zlow, 32'h00001234);
    check("clr_add_zhigh", Zhigh, 0);
    dcnt = 0;
    bcnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done === 1'b1) dcnt++;
      if (busy === 1'b1) bcnt++;
    end
    check("clr_no_done", 64'(dcnt), 0);
    check("clr_no_busy", 64'(bcnt), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
